// File: rtl/memory_access.sv
//------------------------------------------------------------------------------
// memory_access : RV32I memory-access stage with a simple req/ready data bus.
// Revision 1.0
//------------------------------------------------------------------------------
`default_nettype none

module memory_access (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_ex_valid,
  input  logic        i_ex_mem_read,
  input  logic        i_ex_mem_write,
  input  logic [2:0]  i_ex_funct3,
  input  logic [31:0] i_ex_result,
  input  logic [31:0] i_ex_write_data,
  input  logic        i_ex_mem_to_reg,
  input  logic        i_ex_rw_sel,
  input  logic        i_ex_reg_write,
  input  logic [4:0]  i_ex_rd,
  input  logic [31:0] i_ex_pc_plus_4,
  output logic        o_ma_stall,
  output logic        o_dmem_req,
  output logic        o_dmem_we,
  output logic [31:0] o_dmem_addr,
  output logic [3:0]  o_dmem_be,
  output logic [31:0] o_dmem_wdata,
  input  logic        i_dmem_ready,
  input  logic [31:0] i_dmem_rdata,
  output logic        o_ma_valid,
  output logic        o_ma_reg_write,
  output logic        o_ma_mem_to_reg,
  output logic        o_ma_rw_sel,
  output logic        o_ma_misaligned,
  output logic [4:0]  o_ma_rd,
  output logic [31:0] o_ma_pc_plus_4,
  output logic [31:0] o_ma_read_data,
  output logic [31:0] o_ma_result
);

  typedef enum logic [0:0] {IDLE = 1'b0, ACCESS = 1'b1} state_t;

  state_t      state_q, state_d;
  logic        dmem_req_q, dmem_req_d;
  logic        dmem_we_q, dmem_we_d;
  logic [31:0] dmem_addr_q, dmem_addr_d;
  logic [3:0]  dmem_be_q, dmem_be_d;
  logic [31:0] dmem_wdata_q, dmem_wdata_d;
  logic [2:0]  pend_funct3_q, pend_funct3_d;
  logic [31:0] pend_result_q, pend_result_d;
  logic [31:0] pend_pc_q, pend_pc_d;
  logic [4:0]  pend_rd_q, pend_rd_d;
  logic        pend_reg_write_q, pend_reg_write_d;
  logic        pend_mem_to_reg_q, pend_mem_to_reg_d;
  logic        pend_rw_sel_q, pend_rw_sel_d;
  logic        ma_valid_q, ma_valid_d;
  logic        ma_reg_write_q, ma_reg_write_d;
  logic        ma_mem_to_reg_q, ma_mem_to_reg_d;
  logic        ma_rw_sel_q, ma_rw_sel_d;
  logic        ma_misaligned_q, ma_misaligned_d;
  logic [4:0]  ma_rd_q, ma_rd_d;
  logic [31:0] ma_pc_q, ma_pc_d;
  logic [31:0] ma_read_data_q, ma_read_data_d;
  logic [31:0] ma_result_q, ma_result_d;

  logic        mem_op, illegal, misaligned, bad;
  logic [3:0]  st_be;
  logic [31:0] st_wdata;
  logic [31:0] ld_shift, ld_data;

  // Classify the incoming request; bad accesses bypass the bus entirely.
  always_comb begin
    mem_op     = i_ex_mem_read | i_ex_mem_write;
    illegal    = (i_ex_mem_read & i_ex_mem_write) |
                 (mem_op & ((i_ex_funct3 == 3'b011) | (i_ex_funct3[2:1] == 2'b11))) |
                 (i_ex_mem_write & i_ex_funct3[2]);
    misaligned = mem_op & (((i_ex_funct3[1:0] == 2'b01) & i_ex_result[0]) |
                           ((i_ex_funct3[1:0] == 2'b10) & (i_ex_result[1:0] != 2'b00)));
    bad        = illegal | misaligned;

    st_be    = 4'b1111;
    st_wdata = i_ex_write_data;
    case (i_ex_funct3[1:0])
      2'b00: begin
        st_be    = 4'b0001 << i_ex_result[1:0];
        st_wdata = {4{i_ex_write_data[7:0]}};
      end
      2'b01: begin
        st_be    = i_ex_result[1] ? 4'b1100 : 4'b0011;
        st_wdata = {2{i_ex_write_data[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    ld_shift = i_dmem_rdata >> {pend_result_q[1:0], 3'b000};
    case (pend_funct3_q)
      3'b000:  ld_data = {{24{ld_shift[7]}}, ld_shift[7:0]};
      3'b100:  ld_data = {24'h0, ld_shift[7:0]};
      3'b001:  ld_data = {{16{ld_shift[15]}}, ld_shift[15:0]};
      3'b101:  ld_data = {16'h0, ld_shift[15:0]};
      default: ld_data = i_dmem_rdata;
    endcase
  end

  always_comb begin
    state_d           = state_q;
    dmem_req_d        = dmem_req_q;
    dmem_we_d         = dmem_we_q;
    dmem_addr_d       = dmem_addr_q;
    dmem_be_d         = dmem_be_q;
    dmem_wdata_d      = dmem_wdata_q;
    pend_funct3_d     = pend_funct3_q;
    pend_result_d     = pend_result_q;
    pend_pc_d         = pend_pc_q;
    pend_rd_d         = pend_rd_q;
    pend_reg_write_d  = pend_reg_write_q;
    pend_mem_to_reg_d = pend_mem_to_reg_q;
    pend_rw_sel_d     = pend_rw_sel_q;
    ma_valid_d        = 1'b0;
    ma_reg_write_d    = 1'b0;
    ma_mem_to_reg_d   = ma_mem_to_reg_q;
    ma_rw_sel_d       = ma_rw_sel_q;
    ma_misaligned_d   = 1'b0;
    ma_rd_d           = ma_rd_q;
    ma_pc_d           = ma_pc_q;
    ma_read_data_d    = ma_read_data_q;
    ma_result_d       = ma_result_q;

    case (state_q)
      IDLE: begin
        if (i_ex_valid && mem_op && !bad) begin
          state_d           = ACCESS;
          dmem_req_d        = 1'b1;
          dmem_we_d         = i_ex_mem_write;
          dmem_addr_d       = {i_ex_result[31:2], 2'b00};
          dmem_be_d         = st_be;
          dmem_wdata_d      = st_wdata;
          pend_funct3_d     = i_ex_funct3;
          pend_result_d     = i_ex_result;
          pend_pc_d         = i_ex_pc_plus_4;
          pend_rd_d         = i_ex_rd;
          pend_reg_write_d  = i_ex_reg_write & ~i_ex_mem_write;
          pend_mem_to_reg_d = i_ex_mem_to_reg;
          pend_rw_sel_d     = i_ex_rw_sel;
        end else if (i_ex_valid) begin
          ma_valid_d      = 1'b1;
          ma_reg_write_d  = i_ex_reg_write & ~bad & ~i_ex_mem_write;
          ma_misaligned_d = bad;
          ma_mem_to_reg_d = i_ex_mem_to_reg;
          ma_rw_sel_d     = i_ex_rw_sel;
          ma_rd_d         = i_ex_rd;
          ma_pc_d         = i_ex_pc_plus_4;
          ma_read_data_d  = 32'h0;
          ma_result_d     = i_ex_result;
        end
      end
      ACCESS: begin
        if (i_dmem_ready) begin
          state_d         = IDLE;
          dmem_req_d      = 1'b0;
          dmem_we_d       = 1'b0;
          dmem_be_d       = 4'b0000;
          ma_valid_d      = 1'b1;
          ma_reg_write_d  = pend_reg_write_q;
          ma_mem_to_reg_d = pend_mem_to_reg_q;
          ma_rw_sel_d     = pend_rw_sel_q;
          ma_rd_d         = pend_rd_q;
          ma_pc_d         = pend_pc_q;
          ma_read_data_d  = dmem_we_q ? 32'h0 : ld_data;
          ma_result_d     = pend_result_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q           <= IDLE;
      dmem_req_q        <= 1'b0;
      dmem_we_q         <= 1'b0;
      dmem_addr_q       <= 32'h0;
      dmem_be_q         <= 4'b0000;
      dmem_wdata_q      <= 32'h0;
      pend_funct3_q     <= 3'b000;
      pend_result_q     <= 32'h0;
      pend_pc_q         <= 32'h0;
      pend_rd_q         <= 5'd0;
      pend_reg_write_q  <= 1'b0;
      pend_mem_to_reg_q <= 1'b0;
      pend_rw_sel_q     <= 1'b0;
      ma_valid_q        <= 1'b0;
      ma_reg_write_q    <= 1'b0;
      ma_mem_to_reg_q   <= 1'b0;
      ma_rw_sel_q       <= 1'b0;
      ma_misaligned_q   <= 1'b0;
      ma_rd_q           <= 5'd0;
      ma_pc_q           <= 32'h0;
      ma_read_data_q    <= 32'h0;
      ma_result_q       <= 32'h0;
    end else begin
      state_q           <= state_d;
      dmem_req_q        <= dmem_req_d;
      dmem_we_q         <= dmem_we_d;
      dmem_addr_q       <= dmem_addr_d;
      dmem_be_q         <= dmem_be_d;
      dmem_wdata_q      <= dmem_wdata_d;
      pend_funct3_q     <= pend_funct3_d;
      pend_result_q     <= pend_result_d;
      pend_pc_q         <= pend_pc_d;
      pend_rd_q         <= pend_rd_d;
      pend_reg_write_q  <= pend_reg_write_d;
      pend_mem_to_reg_q <= pend_mem_to_reg_d;
      pend_rw_sel_q     <= pend_rw_sel_d;
      ma_valid_q        <= ma_valid_d;
      ma_reg_write_q    <= ma_reg_write_d;
      ma_mem_to_reg_q   <= ma_mem_to_reg_d;
      ma_rw_sel_q       <= ma_rw_sel_d;
      ma_misaligned_q   <= ma_misaligned_d;
      ma_rd_q           <= ma_rd_d;
      ma_pc_q           <= ma_pc_d;
      ma_read_data_q    <= ma_read_data_d;
      ma_result_q       <= ma_result_d;
    end
  end

  assign o_ma_stall      = (state_q == ACCESS);
  assign o_dmem_req      = dmem_req_q;
  assign o_dmem_we       = dmem_we_q;
  assign o_dmem_addr     = dmem_addr_q;
  assign o_dmem_be       = dmem_be_q;
  assign o_dmem_wdata    = dmem_wdata_q;
  assign o_ma_valid      = ma_valid_q;
  assign o_ma_reg_write  = ma_reg_write_q;
  assign o_ma_mem_to_reg = ma_mem_to_reg_q;
  assign o_ma_rw_sel     = ma_rw_sel_q;
  assign o_ma_misaligned = ma_misaligned_q;
  assign o_ma_rd         = ma_rd_q;
  assign o_ma_pc_plus_4  = ma_pc_q;
  assign o_ma_read_data  = ma_read_data_q;
  assign o_ma_result     = ma_result_q;

endmodule

`default_nettype wire

// File: tb/tb_memory_access.sv
//------------------------------------------------------------------------------
// tb_memory_access : directed + randomized bench with a behavioural load/store model.
// Revision 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_memory_access;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid, ex_mem_read, ex_mem_write;
  logic [2:0]  ex_funct3;
  logic [31:0] ex_result, ex_write_data, ex_pc_plus_4;
  logic        ex_mem_to_reg, ex_rw_sel, ex_reg_write;
  logic [4:0]  ex_rd;
  logic        ma_stall, dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_ready;
  logic [31:0] dmem_rdata;
  logic        ma_valid, ma_reg_write, ma_mem_to_reg, ma_rw_sel, ma_misaligned;
  logic [4:0]  ma_rd;
  logic [31:0] ma_pc_plus_4, ma_read_data, ma_result;

  int total  = 0;
  int passed = 0;
  int failed = 0;

  logic [31:0] last_read_data, last_wdata;
  logic [3:0]  last_be;
  int          last_stall_cycles;

  always #5 clk = ~clk;

  memory_access dut (
    .i_clk(clk), .i_rst(rst),
    .i_ex_valid(ex_valid), .i_ex_mem_read(ex_mem_read), .i_ex_mem_write(ex_mem_write),
    .i_ex_funct3(ex_funct3), .i_ex_result(ex_result), .i_ex_write_data(ex_write_data),
    .i_ex_mem_to_reg(ex_mem_to_reg), .i_ex_rw_sel(ex_rw_sel), .i_ex_reg_write(ex_reg_write),
    .i_ex_rd(ex_rd), .i_ex_pc_plus_4(ex_pc_plus_4),
    .o_ma_stall(ma_stall), .o_dmem_req(dmem_req), .o_dmem_we(dmem_we),
    .o_dmem_addr(dmem_addr), .o_dmem_be(dmem_be), .o_dmem_wdata(dmem_wdata),
    .i_dmem_ready(dmem_ready), .i_dmem_rdata(dmem_rdata),
    .o_ma_valid(ma_valid), .o_ma_reg_write(ma_reg_write), .o_ma_mem_to_reg(ma_mem_to_reg),
    .o_ma_rw_sel(ma_rw_sel), .o_ma_misaligned(ma_misaligned), .o_ma_rd(ma_rd),
    .o_ma_pc_plus_4(ma_pc_plus_4), .o_ma_read_data(ma_read_data), .o_ma_result(ma_result)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total = total + 1;
    assert (obs === exp) passed = passed + 1;
    else begin
      failed = failed + 1;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Reference: what the memory stage should do with one instruction, from the ISA rules.
  task automatic model(input bit rd, input bit wr, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] rdata,
                       output bit access, output bit bad, output logic [3:0] be,
                       output logic [31:0] wexp, output logic [31:0] rexp);
    int unsigned size, off;
    longint unsigned v, mask;
    off  = addr % 4;
    size = 1 << (f3 % 4);
    bad  = (rd && wr) || ((rd || wr) && (f3 == 3 || f3 >= 6)) || (wr && f3 >= 3);
    if (!bad && (rd || wr) && (addr % size != 0)) bad = 1;
    access = (rd || wr) && !bad;
    be   = 4'(((1 << size) - 1) << off);
    if (size == 1)      wexp = (wd & 32'hFF) * 32'h01010101;
    else if (size == 2) wexp = (wd & 32'hFFFF) * 32'h00010001;
    else                wexp = wd;
    mask = (64'd1 << (8 * size)) - 1;
    v    = (longint'(rdata) >> (8 * off)) & mask;
    if (f3 < 4 && size < 4 && v >= (mask + 1) / 2) v = v + (64'hFFFFFFFF - mask);
    rexp = rd ? 32'(v) : 32'h0;
  endtask

  task automatic run_op(input string tag, input bit rd, input bit wr, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] rdata,
                        input int waits);
    bit access, bad, regw;
    logic [3:0]  be_e;
    logic [31:0] wexp, rexp, pc;
    logic [4:0]  rdr;
    model(rd, wr, f3, addr, wd, rdata, access, bad, be_e, wexp, rexp);
    regw = 1'($urandom_range(0, 1));
    rdr  = 5'($urandom_range(1, 31));
    pc   = $urandom;
    ex_valid = 1; ex_mem_read = rd; ex_mem_write = wr; ex_funct3 = f3;
    ex_result = addr; ex_write_data = wd; ex_reg_write = regw; ex_rd = rdr;
    ex_pc_plus_4 = pc; ex_mem_to_reg = rd; ex_rw_sel = 1'($urandom_range(0, 1));
    step();
    last_stall_cycles = 0;
    if (access) begin
      chk({tag, ".req"},   32'(dmem_req), 32'd1);
      chk({tag, ".addr"},  dmem_addr, addr & 32'hFFFFFFFC);
      chk({tag, ".we"},    32'(dmem_we), 32'(wr));
      chk({tag, ".be"},    32'(dmem_be), 32'(be_e));
      if (wr) chk({tag, ".wdata"}, dmem_wdata, wexp);
      chk({tag, ".bubble"}, 32'(ma_valid), 32'd0);
      last_be = dmem_be; last_wdata = dmem_wdata;
      // Junk on the EX side while stalled must not leak into the pending access.
      ex_result = $urandom; ex_rd = 5'($urandom); ex_mem_write = 1'($urandom_range(0, 1));
      ex_write_data = $urandom; ex_pc_plus_4 = $urandom;
      for (int i = 0; i < waits; i++) begin
        if (ma_stall) last_stall_cycles++;
        step();
        chk({tag, ".wait_req"},  32'(dmem_req), 32'd1);
        chk({tag, ".wait_addr"}, dmem_addr, addr & 32'hFFFFFFFC);
        chk({tag, ".wait_bub"},  32'(ma_valid), 32'd0);
      end
      if (ma_stall) last_stall_cycles++;
      dmem_ready = 1; dmem_rdata = rdata;
      chk({tag, ".rdy_be"}, 32'(dmem_be), 32'(be_e));
      step();
      dmem_ready = 0; dmem_rdata = $urandom;
      chk({tag, ".stall_cyc"}, 32'(last_stall_cycles), 32'(waits + 1));
      chk({tag, ".misal"},  32'(ma_misaligned), 32'd0);
    end else begin
      chk({tag, ".misal"},  32'(ma_misaligned), 32'(bad));
    end
    chk({tag, ".valid"},  32'(ma_valid), 32'd1);
    chk({tag, ".regw"},   32'(ma_reg_write), 32'((bad || wr) ? 1'b0 : regw));
    chk({tag, ".rdata"},  ma_read_data, access ? rexp : 32'h0);
    chk({tag, ".result"}, ma_result, addr);
    chk({tag, ".rd"},     32'(ma_rd), 32'(rdr));
    chk({tag, ".pc"},     ma_pc_plus_4, pc);
    chk({tag, ".req_off"}, 32'(dmem_req), 32'd0);
    chk({tag, ".stall_off"}, 32'(ma_stall), 32'd0);
    last_read_data = ma_read_data;
    ex_valid = 0;
  endtask

  initial begin
    rst = 1; ex_valid = 0; ex_mem_read = 0; ex_mem_write = 0; ex_funct3 = 0;
    ex_result = 0; ex_write_data = 0; ex_pc_plus_4 = 0; ex_mem_to_reg = 0;
    ex_rw_sel = 0; ex_reg_write = 0; ex_rd = 0; dmem_ready = 0; dmem_rdata = 0;
    step(); step();
    chk("rst.stall", 32'(ma_stall), 32'd0);
    chk("rst.req",   32'(dmem_req), 32'd0);
    chk("rst.valid", 32'(ma_valid), 32'd0);
    chk("rst.regw",  32'(ma_reg_write), 32'd0);
    chk("rst.rdata", ma_read_data, 32'h0);
    chk("rst.addr",  dmem_addr, 32'h0);
    rst = 0;
    step();

    // ADD: single-cycle pass-through
    run_op("add", 0, 0, 3'b000, 32'h10, 32'h0, 32'h0, 0);
    chk("add.result_k", ma_result, 32'h10);

    // LB 0x1003 with three wait cycles
    run_op("lb", 1, 0, 3'b000, 32'h1003, 32'h0, 32'h80FFFFFF, 3);
    chk("lb.data_k",  last_read_data, 32'hFFFFFF80);
    chk("lb.stall_k", 32'(last_stall_cycles), 32'd4);

    // SH 0x2002 ready immediately
    run_op("sh", 0, 1, 3'b001, 32'h2002, 32'h0000BEEF, 32'h0, 0);
    chk("sh.be_k",    32'(last_be), 32'hC);
    chk("sh.wdata_k", last_wdata, 32'hBEEFBEEF);

    run_op("lw_mis", 1, 0, 3'b010, 32'h3001, 32'h0, 32'h0, 0);
    run_op("lhu",    1, 0, 3'b101, 32'h4002, 32'h0, 32'h80011234, 1);
    chk("lhu.data_k", last_read_data, 32'h00008001);
    run_op("both",   1, 1, 3'b010, 32'h5000, 32'h0, 32'h0, 0);
    run_op("sb_ill", 0, 1, 3'b100, 32'h5000, 32'h0, 32'h0, 0);

    // Empty slot
    step();
    chk("bubble.valid", 32'(ma_valid), 32'd0);
    chk("bubble.regw",  32'(ma_reg_write), 32'd0);

    // Reset in the middle of an access
    ex_valid = 1; ex_mem_read = 1; ex_mem_write = 0; ex_funct3 = 3'b010;
    ex_result = 32'h6000; ex_reg_write = 1;
    step();
    ex_valid = 0;
    chk("rstacc.stall", 32'(ma_stall), 32'd1);
    rst = 1;
    step();
    rst = 0; dmem_ready = 1; dmem_rdata = 32'h12345678;
    chk("rstacc.req",   32'(dmem_req), 32'd0);
    chk("rstacc.stall0", 32'(ma_stall), 32'd0);
    step();
    dmem_ready = 0;
    chk("rstacc.valid", 32'(ma_valid), 32'd0);
    chk("rstacc.req2",  32'(dmem_req), 32'd0);
    chk("rstacc.stall1", 32'(ma_stall), 32'd0);

    // Random instruction mix
    for (int n = 0; n < 60; n++) begin
      int kind;
      kind = $urandom_range(0, 9);
      run_op("rnd", kind inside {[3:6]} || kind == 9, kind inside {[7:9]},
             3'($urandom_range(0, 7)),
             (kind < 3) ? $urandom : (32'h8000 + $urandom_range(0, 63)),
             $urandom, $urandom, $urandom_range(0, 3));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
